octal_request_encoder: RTL and testbench

OCTAL_REQUEST_ENCODER -- requirements
Module: octal_request_encoder

---
 rtl/octal_request_encoder.sv | 103 ++++++++++
 tb/tb_octal_request_encoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/octal_request_encoder.sv
// Round-robin encoder: collects 8 event lines into a pending set and streams
// one 3-bit code per transfer over a valid/ready handshake.
module octal_request_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       ready,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending,
  output logic [3:0] pend_cnt,
  output logic       busy,
  output logic       drop
);

  logic [7:0] pending_q, pending_d;
  logic [2:0] code_q, code_d;
  logic [2:0] ptr_q, ptr_d;
  logic       valid_q, valid_d;
  logic       drop_q, drop_d;

  logic       slot_free_s;
  logic       grant_s;
  logic       found_s;
  logic [2:0] grant_idx_s;
  logic [7:0] clr_s;
  logic [3:0] cnt_s;

  // First pending bit at or above ptr, wrapping 7->0
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] probe;
      probe = ptr_q + 3'(i);
      if (!found_s && pending_q[probe]) begin
        found_s     = 1'b1;
        grant_idx_s = probe;
      end else begin
        found_s     = found_s;
      end
    end
  end

  always_comb begin
    slot_free_s = !valid_q || ready;
    grant_s     = slot_free_s && found_s;
    if (grant_s) begin
      clr_s = 8'd1 << grant_idx_s;
    end else begin
      clr_s = 8'd0;
    end

    // A new request on the granted bit re-arms it rather than counting as a drop
    pending_d = (pending_q & ~clr_s) | req;
    drop_d    = |(req & pending_q & ~clr_s);

    if (grant_s) begin
      code_d  = grant_idx_s;
      valid_d = 1'b1;
      ptr_d   = grant_idx_s + 3'd1;
    end else if (slot_free_s) begin
      code_d  = code_q;
      valid_d = 1'b0;
      ptr_d   = ptr_q;
    end else begin
      code_d  = code_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 8'h00;
      code_q    <= 3'd0;
      ptr_q     <= 3'd0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    cnt_s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_s = cnt_s + {3'b000, pending_q[i]};
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign pend_cnt = cnt_s;
  assign busy     = valid_q || (pending_q != 8'h00);
  assign drop     = drop_q;

endmodule

// File: tb/tb_octal_request_encoder.sv
// Scoreboard bench: a behavioural model predicts grants into a queue; a monitor
// pops and compares each code when the DUT transfers it.
module tb_octal_request_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       ready = 1'b0;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic [3:0] pend_cnt;
  logic       busy;
  logic       drop;

  int errors = 0;
  int checks = 0;

  int exp_q[$];

  // model state
  bit m_pend[8];
  int m_ptr = 0;
  bit m_valid = 1'b0;
  int m_code = 0;
  bit m_drop = 1'b0;

  octal_request_encoder dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
    .code(code), .valid(valid), .pending(pending), .pend_cnt(pend_cnt),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  g;
    bit  free;
    if (!rst_n) begin
      foreach (m_pend[k]) m_pend[k] = 1'b0;
      m_ptr = 0; m_valid = 1'b0; m_code = 0; m_drop = 1'b0;
      exp_q.delete();
      return;
    end
    free = !m_valid || ready;
    g = -1;
    if (free) begin
      for (int s = 0; s < 8; s++) begin
        if (g < 0 && m_pend[(m_ptr + s) % 8]) g = (m_ptr + s) % 8;
      end
    end
    m_drop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (req[k] && m_pend[k] && k != g) m_drop = 1'b1;
    end
    if (g >= 0) m_pend[g] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (req[k]) m_pend[k] = 1'b1;
    end
    if (g >= 0) begin
      m_code = g; m_valid = 1'b1; m_ptr = (g + 1) % 8;
      exp_q.push_back(g);
    end else if (free) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_state();
    int cnt;
    logic [7:0] pv;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      pv[k] = m_pend[k];
      cnt += int'(m_pend[k]);
    end
    chk("valid", valid, m_valid);
    if (m_valid) chk("code", code, m_code);
    else if (!rst_n) chk("code_reset", code, 0);
    chk("pending", pending, pv);
    chk("pend_cnt", pend_cnt, cnt);
    chk("busy", busy, (m_valid || cnt != 0));
    chk("drop", drop, m_drop);
  endtask

  task automatic cycle(input logic [7:0] r, input logic rd, input logic rn);
    req = r; ready = rd; rst_n = rn;
    @(posedge clk);
    model_edge();
    #1;
    check_state();
    #1;
  endtask

  // Monitor: a transfer happens at the coming edge when valid && ready out of reset
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_transfer: got code %0d expected none", code);
      end else begin
        chk("xfer_code", code, exp_q.pop_front());
      end
    end
  end

  initial begin
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0);
    // idle, then single request for code 3
    repeat (4) cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h08, 1'b1, 1'b1);
    repeat (4) cycle(8'h00, 1'b1, 1'b1);
    // all eight at once
    cycle(8'hFF, 1'b1, 1'b1);
    repeat (11) cycle(8'h00, 1'b1, 1'b1);
    // ptr=5 with pending 8'h23 exercises the wrap
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h10, 1'b1, 1'b1);
    cycle(8'h23, 1'b1, 1'b1);
    repeat (5) cycle(8'h00, 1'b1, 1'b1);
    // backpressure with duplicate requests
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h04, 1'b0, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h04, 1'b0, 1'b1);
    cycle(8'h04, 1'b0, 1'b1);
    repeat (3) cycle(8'h00, 1'b0, 1'b1);
    repeat (4) cycle(8'h00, 1'b1, 1'b1);
    // grant of 6 coincides with req[6]
    cycle(8'h40, 1'b1, 1'b1);
    cycle(8'h40, 1'b1, 1'b1);
    repeat (4) cycle(8'h00, 1'b1, 1'b1);
    // reset mid-operation
    cycle(8'h81, 1'b1, 1'b1);
    cycle(8'h81, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h81, 1'b1, 1'b1);
    repeat (4) cycle(8'h00, 1'b1, 1'b1);
    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] r;
      logic rd, rn;
      r  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (8'd1 << $urandom_range(0, 7)) & {8{$urandom_range(0, 1) == 1}};
      rd = ($urandom_range(0, 3) != 0);
      rn = ($urandom_range(0, 199) != 0);
      cycle(r, rd, rn);
    end
    repeat (20) cycle(8'h00, 1'b1, 1'b1);
    chk("drained_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
